// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states
// and default datapath width.
package alu_arb_pkg;

   localparam int unsigned WIDTH_DEF = 4;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant; prio picks the winner only when
// both requesters are valid.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       prio,
   output logic [1:0] grant,
   output logic       any
);

   always_comb begin
      grant = '0;
      if (valid == 2'b11) begin
         grant[prio] = 1'b1;
      end else begin
         grant = valid;
      end
   end

   assign any = |valid;

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin accept,
// registered operands, one-cycle ALU settle, held response, done counter.
module alu_req_arbiter
   import alu_arb_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [1:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [1:0]       req1_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] alu_res,
   input  logic             alu_cout,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_res,
   output logic             rsp_cout,
   output logic             rsp_id,
   output logic             busy,
   output logic [CNT_W-1:0] done_count
);

   state_t     state;
   logic       prio;
   logic       cur_id;
   logic [1:0] grant;
   logic       any;

   rr_arb2 u_arb (
      .valid ({req1_valid, req0_valid}),
      .prio  (prio),
      .grant (grant),
      .any   (any)
   );

   assign req0_ready = (state == IDLE) && grant[0];
   assign req1_ready = (state == IDLE) && grant[1];
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         prio       <= 1'b0;
         cur_id     <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         rsp_valid  <= 1'b0;
         rsp_res    <= '0;
         rsp_cout   <= 1'b0;
         rsp_id     <= 1'b0;
         done_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any) begin
                  if (grant[1]) begin
                     alu_a  <= req1_a;
                     alu_b  <= req1_b;
                     alu_op <= req1_op;
                  end else begin
                     alu_a  <= req0_a;
                     alu_b  <= req0_b;
                     alu_op <= req0_op;
                  end
                  cur_id <= grant[1];
                  // Next contest favours whoever did not just win.
                  prio   <= ~grant[1];
                  state  <= EXEC;
               end
            end
            EXEC: begin
               rsp_res   <= alu_res;
               rsp_cout  <= alu_cout;
               rsp_id    <= cur_id;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (done_count != '1) begin
                     done_count <= done_count + 1'b1;
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
